// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory: synchronous byte/half/word stores, combinational word reads.
// Optional memory-mapped console on byte 255 is enabled by defining DATA_MEM_CONSOLE_EN.
module data_mem #(
    parameter int         DEPTH    = 256,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [$clog2(DEPTH)-1:0] ADDR,
    input  logic [31:0]              DIN,
    input  logic                     wren,
    input  logic [2:0]               func3,
    output logic [31:0]              DOUT
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    MEM [0:DEPTH-1];
    logic [AW-1:0] byte_addr [0:3];
    logic [3:0]    byte_en;

    // Lane i always addresses ADDR+i; the AW-bit sum gives the modulo wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byte_addr[i] = ADDR + AW'(i);
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        if (wren) begin
            case (func3)
                3'b000:  byte_en = 4'b0001;
                3'b001:  byte_en = 4'b0011;
                3'b010:  byte_en = 4'b1111;
                default: byte_en = 4'b0000;
            endcase
        end
    end

    assign DOUT = {MEM[byte_addr[3]], MEM[byte_addr[2]], MEM[byte_addr[1]], MEM[byte_addr[0]]};

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                MEM[i] <= INIT_VAL;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    MEM[byte_addr[i]] <= DIN[8*i +: 8];
                end
            end
        end
    end

`ifdef DATA_MEM_CONSOLE_EN
    logic       console_hit;
    logic [7:0] console_byte;

    always_comb begin
        console_hit  = 1'b0;
        console_byte = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i] && (byte_addr[i] == AW'(DEPTH - 1))) begin
                console_hit  = 1'b1;
                console_byte = DIN[8*i +: 8];
            end
        end
    end

    always @(posedge clock) begin
        if (clear && console_hit) begin
            $write("%c", console_byte);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed test-plan steps followed by random stores
// checked against a byte-array reference model.
module tb_data_mem;

    logic        clock;
    logic        clear;
    logic [7:0]  ADDR;
    logic [31:0] DIN;
    logic        wren;
    logic [2:0]  func3;
    logic [31:0] DOUT;

    int total;
    int bad;

    logic [7:0] ref_mem [0:255];

    data_mem dut (
        .clock (clock),
        .clear (clear),
        .ADDR  (ADDR),
        .DIN   (DIN),
        .wren  (wren),
        .func3 (func3),
        .DOUT  (DOUT)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = ref_mem[(int'(a) + i) % 256];
        end
        return w;
    endfunction

    task automatic model_store(input logic [7:0] a, input logic [31:0] d, input logic [2:0] f3);
        int n;
        case (f3)
            3'b000:  n = 1;
            3'b001:  n = 2;
            3'b010:  n = 4;
            default: n = 0;
        endcase
        for (int i = 0; i < n; i++) begin
            ref_mem[(int'(a) + i) % 256] = d[8*i +: 8];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
        end
    endtask

    // Drive one store on the falling edge, check old data before the edge and new data after.
    task automatic do_store(input string tag, input logic [7:0] a, input logic [31:0] d,
                            input logic [2:0] f3, input logic we);
        @(negedge clock);
        ADDR  = a;
        DIN   = d;
        func3 = f3;
        wren  = we;
        #1;
        check({tag, "_pre"}, DOUT, model_read(a));
        @(posedge clock);
        if (we) model_store(a, d, f3);
        #1;
        check({tag, "_post"}, DOUT, model_read(a));
        wren = 1'b0;
    endtask

    task automatic read_at(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clock);
        ADDR = a;
        #1;
        check(tag, DOUT, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear = 1'b0;
        ADDR  = 8'h00;
        DIN   = 32'h0;
        wren  = 1'b0;
        func3 = 3'b000;
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        check("reset_dout", DOUT, 32'h0000_0000);
        @(negedge clock);
        clear = 1'b1;

        // Asynchronous reset with no clock edge.
        do_store("deadbeef", 8'd8, 32'hDEAD_BEEF, 3'b010, 1'b1);
        check("deadbeef_val", DOUT, 32'hDEAD_BEEF);
        @(negedge clock);
        #1 clear = 1'b0;
        #1;
        check("async_reset", DOUT, 32'h0000_0000);
        clear = 1'b1;
        model_reset();

        // Store presented while reset is held is lost.
        @(negedge clock);
        clear = 1'b0;
        ADDR  = 8'd8;
        DIN   = 32'h1234_5678;
        func3 = 3'b010;
        wren  = 1'b1;
        @(posedge clock);
        #1;
        check("store_in_reset", DOUT, 32'h0000_0000);
        @(negedge clock);
        wren  = 1'b0;
        clear = 1'b1;
        #1;
        check("after_release", DOUT, 32'h0000_0000);

        do_store("word", 8'd4, 32'h1122_3344, 3'b010, 1'b1);
        check("word_val", DOUT, 32'h1122_3344);
        check("word_mem4", 32'(dut.MEM[4]), 32'h44);
        check("word_mem7", 32'(dut.MEM[7]), 32'h11);

        do_store("byte", 8'd5, 32'hFFFF_FFAA, 3'b000, 1'b1);
        do_store("half", 8'd6, 32'h0000_BBCC, 3'b001, 1'b1);
        read_at("byte_half", 8'd4, 32'hBBCC_AA44);

        do_store("illegal_f3", 8'd4, 32'h5555_5555, 3'b011, 1'b1);
        do_store("wren_off", 8'd4, 32'h6666_6666, 3'b010, 1'b0);
        read_at("unchanged", 8'd4, 32'hBBCC_AA44);

        do_store("wrap", 8'd255, 32'hA1B2_C3D4, 3'b010, 1'b1);
        check("wrap_val", DOUT, 32'hA1B2_C3D4);
        check("wrap_mem255", 32'(dut.MEM[255]), 32'hD4);
        check("wrap_mem0", 32'(dut.MEM[0]), 32'hC3);
        check("wrap_mem2", 32'(dut.MEM[2]), 32'hA1);
        check("wrap_mem3", 32'(dut.MEM[3]), 32'h00);

        do_store("half_wrap", 8'd255, 32'h0000_7788, 3'b001, 1'b1);
        read_at("half_wrap_rd", 8'd254, model_read(8'd254));

        for (int n = 0; n < 300; n++) begin
            do_store("rand", 8'($urandom_range(0, 255)), $urandom,
                     3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
            if (n % 10 == 0) begin
                logic [7:0] ra;
                ra = 8'($urandom_range(0, 255));
                read_at("rand_read", ra, model_read(ra));
            end
        end

        for (int i = 0; i < 256; i++) begin
            check("final_mem", 32'(dut.MEM[i]), 32'(ref_mem[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
